// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and helpers for the multi-cycle execute unit:
//               operation encodings, control-state encoding, op classifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation encodings; codes 14 and 15 are reserved and produce zero.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_DIV  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REM  = 4'd12,
        OP_REMU = 4'd13
    } alu_op_t;

    // Control state of the execute unit.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    // True for any of the four M-extension divide/remainder ops.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // True for the signed divide/remainder ops.
    function automatic logic is_signed_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // True when the remainder, not the quotient, is the wanted result.
    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Radix-2 restoring divider, one quotient bit per cycle.
//               Works on magnitudes and sign-corrects on the final step.
//               o_done/o_result are valid in the cycle of the last iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_abort,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic            i_rem,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_sel_rem;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN:0]    w_trial;
    logic             w_fits;
    logic [XLEN-1:0]  w_rem_next;
    logic [XLEN-1:0]  w_quo_next;

    assign w_a_neg = i_signed & i_a[XLEN-1];
    assign w_b_neg = i_signed & i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    // The partial remainder is always below the divisor, so the restored value
    // never needs more than XLEN bits.
    assign w_trial    = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
    assign w_fits     = ~w_trial[XLEN];
    assign w_rem_next = w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_quo_next = {r_quo[XLEN-2:0], w_fits};

    assign o_done   = (r_cnt == CNT_W'(1));
    assign o_result = r_sel_rem ? (r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next)
                                : (r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next);

    // Load operands on start, then iterate one bit per cycle until the count expires.
    always_ff @(posedge clk) begin
        if (!reset || i_abort) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
        end else if (i_start) begin
            r_cnt     <= CNT_W'(XLEN);
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_dvs     <= w_b_mag;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_sel_rem <= i_rem;
        end else if (r_cnt != '0) begin
            r_cnt     <= r_cnt - CNT_W'(1);
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle integer execute unit. Single-cycle ALU ops plus
//               iterative divide, valid/ready handshake on both sides, and a
//               registered output that holds under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(XLEN);

    state_t           r_state;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] r_div_tag;

    logic [SH_W-1:0]  w_shamt;
    logic [XLEN-1:0]  w_simple;
    logic [XLEN-1:0]  w_special;
    logic [XLEN-1:0]  w_fast_res;
    logic             w_is_div;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_accept;
    logic             w_div_start;
    logic             w_div_done;
    logic [XLEN-1:0]  w_div_result;

    assign w_shamt    = in_b[SH_W-1:0];
    assign w_is_div   = is_div_op(in_op);
    assign w_div_zero = (in_b == '0);
    assign w_div_ovf  = is_signed_div(in_op) && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);

    // Divide-by-zero and signed overflow resolve immediately without iterating.
    assign w_special  = w_div_zero ? (is_rem_op(in_op) ? in_a : '1)
                                   : (is_rem_op(in_op) ? '0 : in_a);
    assign w_fast_res = w_is_div ? w_special : w_simple;

    assign in_ready    = reset && !flush && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_div_start = w_accept && w_is_div && !w_div_zero && !w_div_ovf;

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

    // Single-cycle datapath; divide ops and reserved codes fall to zero here.
    always_comb begin
        w_simple = '0;
        case (in_op)
            OP_ADD:  w_simple = in_a + in_b;
            OP_SUB:  w_simple = in_a - in_b;
            OP_AND:  w_simple = in_a & in_b;
            OP_OR:   w_simple = in_a | in_b;
            OP_XOR:  w_simple = in_a ^ in_b;
            OP_SLL:  w_simple = in_a << w_shamt;
            OP_SRL:  w_simple = in_a >> w_shamt;
            OP_SRA:  w_simple = XLEN'($signed(in_a) >>> w_shamt);
            OP_SLT:  w_simple = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: w_simple = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default: w_simple = '0;
        endcase
    end

    div_unit #(
        .XLEN (XLEN)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .i_abort  (flush),
        .i_start  (w_div_start),
        .i_signed (is_signed_div(in_op)),
        .i_rem    (is_rem_op(in_op)),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_done   (w_div_done),
        .o_result (w_div_result)
    );

    // Control FSM and output register: consume, reload, or launch a divide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_div_tag    <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_div_start) begin
                            r_state   <= ST_DIV;
                            r_div_tag <= in_tag;
                        end else begin
                            r_out_valid  <= 1'b1;
                            r_out_result <= w_fast_res;
                            r_out_tag    <= in_tag;
                        end
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_out_valid  <= 1'b1;
                        r_out_result <= w_div_result;
                        r_out_tag    <= r_div_tag;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
